thermostat_ctrl: RTL and testbench
==================================

THERMOSTAT_CTRL -- requirements
Module: thermostat_ctrl

Interface
REQ-001 The block SHALL have parameter DEBOUNCE, default 3: consecutive identical valid samples needed to accept a zone change; legal range 1..7.
REQ-002 The block SHALL have parameter MIN_RUN, default 8: minimum clock cycles HEAT/COOL stays active; legal range 1..15.
REQ-003 The block SHALL have parameter DEAD, default 4: clock cycles HOLD must wait after leaving HEAT/COOL; legal range 0..15.
REQ-004 clk  input  1  system clock, all state changes on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 enable  input  1  1 = regulate, 0 = force IDLE.
REQ-007 sample_valid  input  1  one-cycle strobe; zone inputs are sampled only when high.
REQ-008 cold, ok, hot  input  1 each  zone flags from the temperature comparator (cold: temp<=11, ok: temp==12, hot: temp>=13).
REQ-009 fault_clr  input  1  one-cycle request to leave FAULT.
REQ-010 heat_on  output  1  heater drive.
REQ-011 cool_on  output  1  cooler drive.
REQ-012 fault  output  1  high while in FAULT.
REQ-013 state  output  3  current state encoding: IDLE=0, HOLD=1, HEAT=2, COOL=3, FAULT=4.

Function
REQ-014 Outputs SHALL be decoded from the state register only: heat_on = (state==HEAT), cool_on = (state==COOL), fault = (state==FAULT); heat_on and cool_on SHALL never both be 1.
REQ-015 A sample SHALL be valid when sample_valid=1 and exactly one of cold/ok/hot is 1; it is invalid when sample_valid=1 and the flags are not one-hot.
REQ-016 Debounce: on a valid sample equal to cand_zone, deb_cnt SHALL increment, saturating at DEBOUNCE; on a valid sample differing from cand_zone, the block SHALL set cand_zone=sample and deb_cnt=1.
REQ-017 stable_zone SHALL be loaded with cand_zone at the same edge at which deb_cnt reaches DEBOUNCE; with DEBOUNCE=1, every valid sample updates stable_zone at its edge.
REQ-018 IDLE -> HOLD at the first edge with enable=1.
REQ-019 HOLD -> HEAT when stable_zone==COLD and dead_cnt==0; HOLD -> COOL when stable_zone==HOT and dead_cnt==0; otherwise the block SHALL stay in HOLD.
REQ-020 On entry to HEAT or COOL, run_cnt SHALL clear to 0, then increment each cycle, saturating at MIN_RUN.
REQ-021 HEAT -> HOLD when run_cnt==MIN_RUN and stable_zone!=COLD; COOL -> HOLD when run_cnt==MIN_RUN and stable_zone!=HOT; HEAT and COOL SHALL never transition directly to each other.
REQ-022 On a HEAT/COOL -> HOLD transition, dead_cnt SHALL load DEAD, then decrement each cycle to 0.
REQ-023 An invalid sample SHALL move any state to FAULT at the next edge.
REQ-024 FAULT -> IDLE SHALL occur only on fault_clr=1; on that edge, cand_zone and stable_zone SHALL reset to OK and deb_cnt to 0.
REQ-025 enable=0 SHALL move HOLD/HEAT/COOL to IDLE at the next edge, regardless of MIN_RUN; it SHALL have no effect on FAULT.
REQ-026 Priority at a single edge SHALL be: invalid sample > fault_clr > enable=0 > normal transition; an invalid sample coinciding with fault_clr SHALL keep the block in FAULT.
REQ-027 Latency: with HOLD, dead_cnt==0 and DEBOUNCE=3, if the third consecutive valid cold sample is at edge k, heat_on SHALL be 1 after edge k+1.
REQ-028 Samples SHALL continue to be debounced in every state, including IDLE.

Reset
REQ-029 When rst_n=0, the block SHALL immediately force: state=IDLE, heat_on=0, cool_on=0, fault=0, cand_zone=stable_zone=OK, deb_cnt=0, run_cnt=0, dead_cnt=0.
REQ-030 Reset asserted mid-HEAT or mid-COOL SHALL drop the drive output within the same cycle, without waiting for a clock edge.
REQ-031 After rst_n deasserts, the first state change SHALL occur at a rising clk edge.

Verification
REQ-032 Defaults, enable=1, three cold samples -> HOLD, then HEAT one edge after the third sample; heat_on=1 for at least 8 cycles even if ok samples arrive immediately.
REQ-033 In HEAT with run_cnt saturated, three hot samples -> HOLD with heat_on=0 for 4 cycles (dead time), then COOL; cool_on never overlaps heat_on.
REQ-034 cold, cold, ok, cold, cold samples -> no HEAT entry (debounce restarted); a third consecutive cold sample -> HEAT.
REQ-035 Sample with cold=1 and hot=1 in HEAT -> FAULT, heat_on=0, fault=1; fault_clr plus an invalid sample in the same cycle -> stays in FAULT; fault_clr alone -> IDLE, then HOLD.
REQ-036 enable=0 at run_cnt=2 in COOL -> IDLE at the next edge with cool_on=0; rst_n pulsed low between edges during HEAT -> heat_on=0 immediately, state=0.

Source files
------------

// File: rtl/thermostat_ctrl_if.sv
// Thermostat controller bus: regulation controls and zone flags in,
// drive outputs and state out.
interface thermostat_ctrl_if;
    logic       enable;
    logic       sample_valid;
    logic       cold;
    logic       ok;
    logic       hot;
    logic       fault_clr;
    logic       heat_on;
    logic       cool_on;
    logic       fault;
    logic [2:0] state;

    // Master side drives the controls and zone flags (environment / bench).
    modport master (
        output enable, sample_valid, cold, ok, hot, fault_clr,
        input  heat_on, cool_on, fault, state
    );

    // Slave side is the controller itself.
    modport slave (
        input  enable, sample_valid, cold, ok, hot, fault_clr,
        output heat_on, cool_on, fault, state
    );
endinterface

// File: rtl/thermostat_ctrl.sv
// Thermostat controller: debounces comparator zone flags and runs a
// HOLD/HEAT/COOL state machine with minimum run time, dead time and fault trap.
module thermostat_ctrl #(
    parameter int unsigned DEBOUNCE = 3,
    parameter int unsigned MIN_RUN  = 8,
    parameter int unsigned DEAD     = 4
) (
    input logic               clk,
    input logic               rst_n,
    thermostat_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HOLD  = 3'd1,
        ST_HEAT  = 3'd2,
        ST_COOL  = 3'd3,
        ST_FAULT = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        Z_COLD = 2'd0,
        Z_OK   = 2'd1,
        Z_HOT  = 2'd2
    } zone_e;

    localparam logic [2:0] DEB_MAX  = 3'(DEBOUNCE);
    localparam logic [3:0] RUN_MAX  = 4'(MIN_RUN);
    localparam logic [3:0] DEAD_LD  = 4'(DEAD);

    state_e     state_q, state_d;
    zone_e      cand_q, cand_d;
    zone_e      stable_q, stable_d;
    logic [2:0] deb_q, deb_d;
    logic [3:0] run_q, run_d;
    logic [3:0] dead_q, dead_d;

    logic       sample_ok;
    logic       sample_bad;
    logic       clr_take;
    zone_e      sample_zone;

    // Classify the incoming sample and detect an accepted fault clear.
    always_comb begin
        sample_ok   = 1'b0;
        sample_bad  = 1'b0;
        sample_zone = Z_OK;
        if (bus.sample_valid) begin
            case ({bus.cold, bus.ok, bus.hot})
                3'b100:  begin sample_ok = 1'b1; sample_zone = Z_COLD; end
                3'b010:  begin sample_ok = 1'b1; sample_zone = Z_OK;   end
                3'b001:  begin sample_ok = 1'b1; sample_zone = Z_HOT;  end
                default: sample_bad = 1'b1;
            endcase
        end
        clr_take = (state_q == ST_FAULT) && bus.fault_clr && !sample_bad;
    end

    // Debounce valid samples into a stable zone; a fault clear restarts from OK.
    always_comb begin
        cand_d   = cand_q;
        deb_d    = deb_q;
        stable_d = stable_q;
        if (clr_take) begin
            cand_d   = Z_OK;
            stable_d = Z_OK;
            deb_d    = 3'd0;
        end else if (sample_ok) begin
            if (sample_zone == cand_q) begin
                if (deb_q < DEB_MAX) begin
                    deb_d = deb_q + 3'd1;
                end
            end else begin
                cand_d = sample_zone;
                deb_d  = 3'd1;
            end
            if (deb_d == DEB_MAX) begin
                stable_d = cand_d;
            end
        end
    end

    // Next-state logic: invalid sample beats fault clear beats disable beats regulation.
    always_comb begin
        state_d = state_q;
        if (sample_bad) begin
            state_d = ST_FAULT;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.enable) state_d = ST_HOLD;
                end
                ST_HOLD: begin
                    if (!bus.enable)                                     state_d = ST_IDLE;
                    else if (dead_q == 4'd0 && stable_q == Z_COLD)       state_d = ST_HEAT;
                    else if (dead_q == 4'd0 && stable_q == Z_HOT)        state_d = ST_COOL;
                end
                ST_HEAT: begin
                    if (!bus.enable)                                     state_d = ST_IDLE;
                    else if (run_q == RUN_MAX && stable_q != Z_COLD)     state_d = ST_HOLD;
                end
                ST_COOL: begin
                    if (!bus.enable)                                     state_d = ST_IDLE;
                    else if (run_q == RUN_MAX && stable_q != Z_HOT)      state_d = ST_HOLD;
                end
                ST_FAULT: begin
                    if (bus.fault_clr) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Run timer counts from entry into a drive state; dead timer arms on leaving it.
    always_comb begin
        run_d = 4'd0;
        if ((state_d == ST_HEAT || state_d == ST_COOL) && state_d == state_q) begin
            run_d = (run_q < RUN_MAX) ? run_q + 4'd1 : run_q;
        end
        dead_d = (dead_q != 4'd0) ? dead_q - 4'd1 : dead_q;
        if ((state_q == ST_HEAT || state_q == ST_COOL) && state_d == ST_HOLD) begin
            dead_d = DEAD_LD;
        end
    end

    // State and counter registers with asynchronous reset to IDLE / zone OK.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cand_q   <= Z_OK;
            stable_q <= Z_OK;
            deb_q    <= 3'd0;
            run_q    <= 4'd0;
            dead_q   <= 4'd0;
        end else begin
            state_q  <= state_d;
            cand_q   <= cand_d;
            stable_q <= stable_d;
            deb_q    <= deb_d;
            run_q    <= run_d;
            dead_q   <= dead_d;
        end
    end

    assign bus.heat_on = (state_q == ST_HEAT);
    assign bus.cool_on = (state_q == ST_COOL);
    assign bus.fault   = (state_q == ST_FAULT);
    assign bus.state   = state_q;
endmodule

// File: tb/tb_thermostat_ctrl.sv
// Directed bench for thermostat_ctrl: a vector table for the main sequence,
// then hand-written sequences for dead time, disable in COOL and async reset.
module tb_thermostat_ctrl;
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HOLD  = 3'd1;
    localparam logic [2:0] S_HEAT  = 3'd2;
    localparam logic [2:0] S_COOL  = 3'd3;
    localparam logic [2:0] S_FAULT = 3'd4;
    localparam int DEAD = 4;
    localparam int MIN_RUN = 8;

    typedef struct {
        string      name;
        logic       sv;
        logic       cold;
        logic       ok;
        logic       hot;
        logic       clr;
        logic       en;
        logic [2:0] exp_state;
    } vec_t;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;
    vec_t vecs[$];

    thermostat_ctrl_if bus ();

    thermostat_ctrl #(.DEBOUNCE(3), .MIN_RUN(MIN_RUN), .DEAD(DEAD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic addVec(input string name, input logic sv, input logic c, input logic o,
                          input logic h, input logic clr, input logic en, input logic [2:0] st);
        vec_t v;
        v.name = name; v.sv = sv; v.cold = c; v.ok = o; v.hot = h;
        v.clr = clr; v.en = en; v.exp_state = st;
        vecs.push_back(v);
    endtask

    // Drive inputs at the falling edge, let one rising edge act, strobes drop after it.
    task automatic applyStimulus(input logic sv, input logic c, input logic o,
                                 input logic h, input logic clr, input logic en);
        @(negedge clk);
        bus.sample_valid = sv;
        bus.cold = c;
        bus.ok = o;
        bus.hot = h;
        bus.fault_clr = clr;
        bus.enable = en;
        @(posedge clk);
        #1;
        bus.sample_valid = 1'b0;
        bus.cold = 1'b0;
        bus.ok = 1'b0;
        bus.hot = 1'b0;
        bus.fault_clr = 1'b0;
    endtask

    // Compare state and every drive output against what the expected state implies.
    task automatic checkOutput(input string name, input logic [2:0] exp_state);
        logic [5:0] exp_v;
        logic [5:0] act_v;
        exp_v = {exp_state, exp_state == S_HEAT, exp_state == S_COOL, exp_state == S_FAULT};
        act_v = {bus.state, bus.heat_on, bus.cool_on, bus.fault};
        tests_run++;
        if (act_v !== exp_v) begin
            tests_failed++;
            $display("[TB] FAIL %s: {state,heat,cool,fault} got %b required %b", name, act_v, exp_v);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        rst_n = 1'b0;
        bus.enable = 1'b0;
        bus.sample_valid = 1'b0;
        bus.cold = 1'b0;
        bus.ok = 1'b0;
        bus.hot = 1'b0;
        bus.fault_clr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_state", S_IDLE);
        rst_n = 1'b1;

        //         name                sv c  o  h  clr en  expected
        addVec("enable_to_hold",       0, 0, 0, 0, 0, 1, S_HOLD);
        addVec("cold1",                1, 1, 0, 0, 0, 1, S_HOLD);
        addVec("cold2",                1, 1, 0, 0, 0, 1, S_HOLD);
        addVec("cold3_stable",         1, 1, 0, 0, 0, 1, S_HOLD);
        addVec("heat_latency",         1, 0, 1, 0, 0, 1, S_HEAT);
        addVec("heat_run1_ok",         1, 0, 1, 0, 0, 1, S_HEAT);
        addVec("heat_run2_ok",         1, 0, 1, 0, 0, 1, S_HEAT);
        for (int i = 3; i <= MIN_RUN; i++) addVec("heat_min_run", 0, 0, 0, 0, 0, 1, S_HEAT);
        addVec("heat_release",         0, 0, 0, 0, 0, 1, S_HOLD);
        addVec("deb_cold1",            1, 1, 0, 0, 0, 1, S_HOLD);
        addVec("deb_cold2",            1, 1, 0, 0, 0, 1, S_HOLD);
        addVec("deb_ok_break",         1, 0, 1, 0, 0, 1, S_HOLD);
        addVec("deb_cold1b",           1, 1, 0, 0, 0, 1, S_HOLD);
        addVec("deb_cold2b_no_heat",   1, 1, 0, 0, 0, 1, S_HOLD);
        addVec("deb_cold3b",           1, 1, 0, 0, 0, 1, S_HOLD);
        addVec("deb_heat_entry",       0, 0, 0, 0, 0, 1, S_HEAT);
        addVec("invalid_cold_hot",     1, 1, 0, 1, 0, 1, S_FAULT);
        addVec("clr_with_invalid",     1, 1, 1, 0, 1, 1, S_FAULT);
        addVec("fault_holds",          0, 0, 0, 0, 0, 1, S_FAULT);
        addVec("fault_ignores_en0",    0, 0, 0, 0, 0, 0, S_FAULT);
        addVec("fault_clr_idle",       0, 0, 0, 0, 1, 1, S_IDLE);
        addVec("idle_to_hold",         0, 0, 0, 0, 0, 1, S_HOLD);
        addVec("zones_cleared_to_ok",  0, 0, 0, 0, 0, 1, S_HOLD);
        addVec("flags_ignored_no_sv",  0, 1, 0, 1, 0, 1, S_HOLD);
        addVec("invalid_no_flags",     1, 0, 0, 0, 0, 1, S_FAULT);
        addVec("fault_clr_idle2",      0, 0, 0, 0, 1, 1, S_IDLE);
        addVec("idle_to_hold2",        0, 0, 0, 0, 0, 1, S_HOLD);
        addVec("hold_en0_idle",        0, 0, 0, 0, 0, 0, S_IDLE);
        addVec("idle_deb_cold1",       1, 1, 0, 0, 0, 0, S_IDLE);
        addVec("idle_deb_cold2",       1, 1, 0, 0, 0, 0, S_IDLE);
        addVec("idle_deb_cold3",       1, 1, 0, 0, 0, 0, S_IDLE);
        addVec("idle_to_hold3",        0, 0, 0, 0, 0, 1, S_HOLD);
        addVec("idle_debounced_heat",  0, 0, 0, 0, 0, 1, S_HEAT);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].sv, vecs[i].cold, vecs[i].ok, vecs[i].hot,
                          vecs[i].clr, vecs[i].en);
            checkOutput(vecs[i].name, vecs[i].exp_state);
        end

        // HEAT saturated, then hot zone: dead time in HOLD before COOL.
        doReset();
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("seqA_hold", S_HOLD);
        for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("seqA_heat", S_HEAT);
        for (int i = 0; i < MIN_RUN; i++) applyStimulus(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, 0, 1, 0, 1);
            checkOutput("seqA_hot_still_heat", S_HEAT);
        end
        // dead_cnt loads at the leaving edge and the exit is decided on the
        // registered zero, so HOLD is seen for DEAD+1 cycles.
        for (int i = 0; i < DEAD + 1; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 1);
            checkOutput("seqA_dead_hold", S_HOLD);
        end
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("seqA_cool_after_dead", S_COOL);

        // Disable two cycles into COOL drops straight to IDLE.
        applyStimulus(0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("seqB_cool_run2", S_COOL);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("seqB_en0_idle", S_IDLE);

        // Asynchronous reset between edges while heating.
        doReset();
        applyStimulus(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("seqC_heating", S_HEAT);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("seqC_async_reset", S_IDLE);
        #1;
        rst_n = 1'b1;
        #1;
        checkOutput("seqC_no_change_before_edge", S_IDLE);
        @(posedge clk);
        #1;
        checkOutput("seqC_hold_after_edge", S_HOLD);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
